// File: rtl/lsu_stage_if.sv
// Data-memory port of the load/store stage.
// The req/gnt/rvalid handshake is bundled here; the LSU is the master.
interface lsu_stage_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic              o_dmem_req;
  logic              i_dmem_gnt;
  logic              o_dmem_we;
  logic [ADDR_W-1:0] o_dmem_addr;
  logic [XLEN-1:0]   o_dmem_wdata;
  logic [XLEN/8-1:0] o_dmem_be;
  logic              i_dmem_rvalid;
  logic [XLEN-1:0]   i_dmem_rdata;

  modport master (
    output o_dmem_req, o_dmem_we, o_dmem_addr,
    output o_dmem_wdata, o_dmem_be,
    input  i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata
  );

  modport slave (
    input  o_dmem_req, o_dmem_we, o_dmem_addr,
    input  o_dmem_wdata, o_dmem_be,
    output i_dmem_gnt, i_dmem_rvalid, i_dmem_rdata
  );
endinterface

// File: rtl/lsu_stage.sv
// Load/store stage between EX-MEM and MEM-WB.
// Runs a req/gnt/rvalid access with stall, lane alignment and a hang watchdog.
module lsu_stage #(
  parameter int XLEN     = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [4:0]        i_rd,
  input  logic              i_reg_write,
  input  logic [1:0]        i_reg_write_src,
  input  logic [ADDR_W-1:0] i_pc_p4,
  output logic              o_stall,
  lsu_stage_if.master       dmem,
  output logic              o_valid,
  output logic [4:0]        o_rd,
  output logic              o_reg_write,
  output logic [1:0]        o_reg_write_src,
  output logic [ADDR_W-1:0] o_pc_p4,
  output logic [ADDR_W-1:0] o_alu_result,
  output logic [XLEN-1:0]   o_load_data,
  output logic              o_misaligned,
  output logic              o_fault
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int WW = $clog2(MAX_WAIT + 1) + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e            state_q, state_d;
  logic [WW-1:0]     wd_q, wd_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]     be_q, be_d;
  logic [2:0]        f3_q, f3_d;
  logic              valid_q, valid_d;
  logic [4:0]        rd_q, rd_d;
  logic              rw_q, rw_d;
  logic [1:0]        src_q, src_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] alu_q, alu_d;
  logic [XLEN-1:0]   ld_q, ld_d;
  logic              mis_q, mis_d;
  logic              flt_q, flt_d;

  logic [1:0]        size;
  logic [OW-1:0]     off;
  logic              mem_op;
  logic              illegal;
  logic              misal;
  logic [NB-1:0]     mask;
  logic [XLEN-1:0]   wrep;
  logic [XLEN-1:0]   sh;
  logic [XLEN-1:0]   ld_ext;
  logic [WW-1:0]     wd_inc;
  logic              tmo;

  assign size   = i_funct3[1:0];
  assign off    = i_addr[OW-1:0];
  assign mem_op = i_mem_read | i_mem_write;
  assign wd_inc = wd_q + WW'(1);
  assign tmo    = wd_inc >= WW'(MAX_WAIT);

  always_comb begin
    illegal = 1'b0;
    if (i_mem_write)
      illegal = i_funct3[2] | (XLEN == 32 && size == 2'd3);
    else if (i_mem_read)
      illegal = (i_funct3 == 3'b111) |
                (XLEN == 32 && (i_funct3 == 3'b011 ||
                                i_funct3 == 3'b110));
  end

  always_comb begin
    misal = 1'b0;
    mask  = '1;
    wrep  = i_wdata;
    unique case (size)
      2'd0: begin
        mask = NB'(1);
        wrep = {NB{i_wdata[7:0]}};
      end
      2'd1: begin
        misal = i_addr[0];
        mask  = NB'(3);
        wrep  = {(NB/2){i_wdata[15:0]}};
      end
      2'd2: begin
        misal = |i_addr[1:0];
        mask  = NB'(15);
        wrep  = {(XLEN/32){i_wdata[31:0]}};
      end
      default: begin
        misal = |i_addr[2:0];
        mask  = '1;
        wrep  = i_wdata;
      end
    endcase
  end

  // Selected lane lands at bit 0 before extension
  assign sh = dmem.i_dmem_rdata >> {alu_q[OW-1:0], 3'b000};

  always_comb begin
    ld_ext = sh;
    unique case (f3_q)
      3'b000:  ld_ext = XLEN'($signed(sh[7:0]));
      3'b001:  ld_ext = XLEN'($signed(sh[15:0]));
      3'b010:  ld_ext = XLEN'($signed(sh[31:0]));
      3'b100:  ld_ext = XLEN'(sh[7:0]);
      3'b101:  ld_ext = XLEN'(sh[15:0]);
      3'b110:  ld_ext = XLEN'(sh[31:0]);
      default: ld_ext = sh;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wd_d    = wd_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    f3_d    = f3_q;
    valid_d = 1'b0;
    rd_d    = rd_q;
    rw_d    = rw_q;
    src_d   = src_q;
    pc_d    = pc_q;
    alu_d   = alu_q;
    ld_d    = ld_q;
    mis_d   = mis_q;
    flt_d   = flt_q;
    o_stall = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          rd_d  = i_rd;
          rw_d  = i_reg_write;
          src_d = i_reg_write_src;
          pc_d  = i_pc_p4;
          alu_d = i_addr;
          ld_d  = '0;
          mis_d = 1'b0;
          flt_d = 1'b0;
          if (!mem_op) begin
            valid_d = 1'b1;
          end else if (illegal) begin
            valid_d = 1'b1;
            flt_d   = 1'b1;
            rw_d    = 1'b0;
          end else if (misal) begin
            valid_d = 1'b1;
            mis_d   = 1'b1;
            rw_d    = 1'b0;
          end else begin
            o_stall = 1'b1;
            state_d = REQ;
            wd_d    = '0;
            req_d   = 1'b1;
            we_d    = i_mem_write;
            addr_d  = {i_addr[ADDR_W-1:OW], OW'(0)};
            wdata_d = wrep;
            be_d    = mask << off;
            f3_d    = i_funct3;
          end
        end
      end
      REQ: begin
        o_stall = 1'b1;
        wd_d    = wd_inc;
        if (dmem.i_dmem_gnt) begin
          req_d = 1'b0;
          if (we_q) begin
            o_stall = 1'b0;
            valid_d = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT;
          end
        end else if (tmo) begin
          o_stall = 1'b0;
          valid_d = 1'b1;
          flt_d   = 1'b1;
          rw_d    = 1'b0;
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      WAIT: begin
        o_stall = 1'b1;
        wd_d    = wd_inc;
        if (dmem.i_dmem_rvalid) begin
          o_stall = 1'b0;
          valid_d = 1'b1;
          ld_d    = ld_ext;
          state_d = IDLE;
        end else if (tmo) begin
          o_stall = 1'b0;
          valid_d = 1'b1;
          flt_d   = 1'b1;
          rw_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wd_q    <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      f3_q    <= '0;
      valid_q <= 1'b0;
      rd_q    <= '0;
      rw_q    <= 1'b0;
      src_q   <= '0;
      pc_q    <= '0;
      alu_q   <= '0;
      ld_q    <= '0;
      mis_q   <= 1'b0;
      flt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wd_q    <= wd_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      f3_q    <= f3_d;
      valid_q <= valid_d;
      rd_q    <= rd_d;
      rw_q    <= rw_d;
      src_q   <= src_d;
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      ld_q    <= ld_d;
      mis_q   <= mis_d;
      flt_q   <= flt_d;
    end
  end

  assign dmem.o_dmem_req   = req_q;
  assign dmem.o_dmem_we    = we_q;
  assign dmem.o_dmem_addr  = addr_q;
  assign dmem.o_dmem_wdata = wdata_q;
  assign dmem.o_dmem_be    = be_q;

  assign o_valid         = valid_q;
  assign o_rd            = rd_q;
  assign o_reg_write     = rw_q;
  assign o_reg_write_src = src_q;
  assign o_pc_p4         = pc_q;
  assign o_alu_result    = alu_q;
  assign o_load_data     = ld_q;
  assign o_misaligned    = mis_q;
  assign o_fault         = flt_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Bench for lsu_stage: vector table driven through a small memory responder,
// results checked by a scoreboard when o_valid fires.
module tb_lsu_stage;

  localparam int MW = 6;

  typedef struct {
    string       nm;
    logic        rd_op;
    logic        wr_op;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic        rw;
    int          gnt_at;
    int          rv_at;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
    int          e_stalls;
    logic        e_mis;
    logic        e_flt;
    logic        e_rw;
    logic [31:0] e_ld;
    logic [31:0] pc;
    logic [1:0]  src;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        i_valid;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic [4:0]  i_rd;
  logic        i_reg_write;
  logic [1:0]  i_reg_write_src;
  logic [31:0] i_pc_p4;
  logic        o_stall;
  logic        o_valid;
  logic [4:0]  o_rd;
  logic        o_reg_write;
  logic [1:0]  o_reg_write_src;
  logic [31:0] o_pc_p4;
  logic [31:0] o_alu_result;
  logic [31:0] o_load_data;
  logic        o_misaligned;
  logic        o_fault;

  lsu_stage_if #(.XLEN(32), .ADDR_W(32)) dmem ();

  lsu_stage #(.XLEN(32), .ADDR_W(32), .MAX_WAIT(MW)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .i_valid         (i_valid),
    .i_mem_read      (i_mem_read),
    .i_mem_write     (i_mem_write),
    .i_funct3        (i_funct3),
    .i_addr          (i_addr),
    .i_wdata         (i_wdata),
    .i_rd            (i_rd),
    .i_reg_write     (i_reg_write),
    .i_reg_write_src (i_reg_write_src),
    .i_pc_p4         (i_pc_p4),
    .o_stall         (o_stall),
    .dmem            (dmem),
    .o_valid         (o_valid),
    .o_rd            (o_rd),
    .o_reg_write     (o_reg_write),
    .o_reg_write_src (o_reg_write_src),
    .o_pc_p4         (o_pc_p4),
    .o_alu_result    (o_alu_result),
    .o_load_data     (o_load_data),
    .o_misaligned    (o_misaligned),
    .o_fault         (o_fault)
  );

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t tbl[$];
  vec_t sb[$];
  vec_t m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input string nm, input logic rd_op, input logic wr_op,
    input logic [2:0] f3, input logic [31:0] addr,
    input logic [31:0] wdata, input logic [31:0] rdata,
    input logic [4:0] rd, input logic rw,
    input int gnt_at, input int rv_at,
    input logic e_req, input logic [31:0] e_addr,
    input logic [31:0] e_wdata, input logic [3:0] e_be,
    input int e_stalls, input logic e_mis, input logic e_flt,
    input logic e_rw, input logic [31:0] e_ld);
    vec_t v;
    v.nm = nm; v.rd_op = rd_op; v.wr_op = wr_op; v.f3 = f3;
    v.addr = addr; v.wdata = wdata; v.rdata = rdata;
    v.rd = rd; v.rw = rw; v.gnt_at = gnt_at; v.rv_at = rv_at;
    v.e_req = e_req; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_be = e_be; v.e_stalls = e_stalls; v.e_mis = e_mis;
    v.e_flt = e_flt; v.e_rw = e_rw; v.e_ld = e_ld;
    v.pc = '0; v.src = '0;
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst && o_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL spurious_valid: got o_valid=1 expected no result");
      end else begin
        m = sb.pop_front();
        chk({m.nm, ".mis"}, 32'(o_misaligned), 32'(m.e_mis));
        chk({m.nm, ".flt"}, 32'(o_fault), 32'(m.e_flt));
        chk({m.nm, ".rw"}, 32'(o_reg_write), 32'(m.e_rw));
        chk({m.nm, ".ld"}, o_load_data, m.e_ld);
        chk({m.nm, ".rd"}, 32'(o_rd), 32'(m.rd));
        chk({m.nm, ".alu"}, o_alu_result, m.addr);
        chk({m.nm, ".pc"}, o_pc_p4, m.pc);
        chk({m.nm, ".src"}, 32'(o_reg_write_src), 32'(m.src));
      end
    end
  end

  task automatic run(input vec_t v);
    int req_cnt = 0;
    int wt_cnt  = 0;
    int stalls  = 0;
    bit granted = 0;
    bit done    = 0;
    @(negedge clk);
    i_valid         = 1'b1;
    i_mem_read      = v.rd_op;
    i_mem_write     = v.wr_op;
    i_funct3        = v.f3;
    i_addr          = v.addr;
    i_wdata         = v.wdata;
    i_rd            = v.rd;
    i_reg_write     = v.rw;
    i_reg_write_src = v.src;
    i_pc_p4         = v.pc;
    dmem.i_dmem_gnt    = 1'b0;
    dmem.i_dmem_rvalid = 1'b0;
    dmem.i_dmem_rdata  = v.rdata;
    sb.push_back(v);
    for (int c = 0; c < 40 && !done; c++) begin
      if (c > 0) begin
        @(negedge clk);
        dmem.i_dmem_gnt    = 1'b0;
        dmem.i_dmem_rvalid = 1'b0;
        if (dmem.o_dmem_req) begin
          req_cnt++;
          if (req_cnt == v.gnt_at) begin
            dmem.i_dmem_gnt = 1'b1;
            granted = 1;
          end
        end else if (granted) begin
          wt_cnt++;
          dmem.i_dmem_rvalid = (wt_cnt == v.rv_at);
        end
      end
      #1;
      if (c == 1)
        chk({v.nm, ".req"}, 32'(dmem.o_dmem_req), 32'(v.e_req));
      if (dmem.o_dmem_req) begin
        chk({v.nm, ".addr"}, dmem.o_dmem_addr, v.e_addr);
        chk({v.nm, ".be"}, 32'(dmem.o_dmem_be), 32'(v.e_be));
        chk({v.nm, ".we"}, 32'(dmem.o_dmem_we), 32'(v.wr_op));
        if (v.wr_op)
          chk({v.nm, ".wdata"}, dmem.o_dmem_wdata, v.e_wdata);
      end
      if (o_stall) stalls++;
      else done = 1;
    end
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s.hang: got stall after 40 cycles expected release", v.nm);
    end
    chk({v.nm, ".stalls"}, 32'(stalls), 32'(v.e_stalls));
    @(negedge clk);
    i_valid            = 1'b0;
    dmem.i_dmem_gnt    = 1'b0;
    dmem.i_dmem_rvalid = 1'b0;
    chk({v.nm, ".valid"}, 32'(o_valid), 32'd1);
    chk({v.nm, ".req_end"}, 32'(dmem.o_dmem_req), 32'd0);
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_funct3 = '0; i_addr = '0; i_wdata = '0; i_rd = '0;
    i_reg_write = 1'b0; i_reg_write_src = '0; i_pc_p4 = '0;
    dmem.i_dmem_gnt = 1'b0; dmem.i_dmem_rvalid = 1'b0;
    dmem.i_dmem_rdata = '0;

    //      name         rd wr f3      addr          wdata         rdata         rd    rw gnt rv req e_addr        e_wdata       be    st mis flt rw e_ld
    tbl.push_back(mk("add",       0, 0, 3'b000, 32'h12345678, 32'h0,        32'h0,        5'd5,  1, 0, 0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 0, 1, 32'h0));
    tbl.push_back(mk("lb",        1, 0, 3'b000, 32'h00001003, 32'h0,        32'h80123456, 5'd6,  1, 2, 3, 1, 32'h1000, 32'h0,        4'h8, 5, 0, 0, 1, 32'hFFFFFF80));
    tbl.push_back(mk("sh",        0, 1, 3'b001, 32'h00002002, 32'h0000BEEF, 32'h0,        5'd0,  0, 1, 0, 1, 32'h2000, 32'hBEEFBEEF, 4'hC, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mk("lw_mis",    1, 0, 3'b010, 32'h00003001, 32'h0,        32'h0,        5'd7,  1, 0, 0, 0, 32'h0,    32'h0,        4'h0, 0, 1, 0, 0, 32'h0));
    tbl.push_back(mk("lbu",       1, 0, 3'b100, 32'h00004001, 32'h0,        32'h1122F344, 5'd8,  1, 1, 1, 1, 32'h4000, 32'h0,        4'h2, 2, 0, 0, 1, 32'h000000F3));
    tbl.push_back(mk("lh",        1, 0, 3'b001, 32'h00004002, 32'h0,        32'h80017777, 5'd9,  1, 1, 2, 1, 32'h4000, 32'h0,        4'hC, 3, 0, 0, 1, 32'hFFFF8001));
    tbl.push_back(mk("lhu",       1, 0, 3'b101, 32'h00004000, 32'h0,        32'h12349ABC, 5'd10, 1, 1, 1, 1, 32'h4000, 32'h0,        4'h3, 2, 0, 0, 1, 32'h00009ABC));
    tbl.push_back(mk("lw",        1, 0, 3'b010, 32'h00005000, 32'h0,        32'hDEADBEEF, 5'd11, 1, 3, 1, 1, 32'h5000, 32'h0,        4'hF, 4, 0, 0, 1, 32'hDEADBEEF));
    tbl.push_back(mk("sb",        0, 1, 3'b000, 32'h00006001, 32'hFFFFFF5A, 32'h0,        5'd0,  0, 1, 0, 1, 32'h6000, 32'h5A5A5A5A, 4'h2, 1, 0, 0, 0, 32'h0));
    tbl.push_back(mk("sw",        0, 1, 3'b010, 32'h00007004, 32'hCAFEF00D, 32'h0,        5'd0,  0, 2, 0, 1, 32'h7004, 32'hCAFEF00D, 4'hF, 2, 0, 0, 0, 32'h0));
    tbl.push_back(mk("ld_ill",    1, 0, 3'b011, 32'h00008000, 32'h0,        32'h0,        5'd12, 1, 0, 0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 1, 0, 32'h0));
    tbl.push_back(mk("lwu_ill",   1, 0, 3'b110, 32'h00008004, 32'h0,        32'h0,        5'd12, 1, 0, 0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 1, 0, 32'h0));
    tbl.push_back(mk("st_ill",    0, 1, 3'b100, 32'h00008008, 32'h0,        32'h0,        5'd0,  0, 0, 0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 1, 0, 32'h0));
    tbl.push_back(mk("f7_ill",    1, 0, 3'b111, 32'h0000800C, 32'h0,        32'h0,        5'd13, 1, 0, 0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 1, 0, 32'h0));
    tbl.push_back(mk("sw_mis",    0, 1, 3'b010, 32'h00009002, 32'h0,        32'h0,        5'd0,  0, 0, 0, 0, 32'h0,    32'h0,        4'h0, 0, 1, 0, 0, 32'h0));
    tbl.push_back(mk("sh_mis",    0, 1, 3'b001, 32'h00009001, 32'h0,        32'h0,        5'd0,  0, 0, 0, 0, 32'h0,    32'h0,        4'h0, 0, 1, 0, 0, 32'h0));
    tbl.push_back(mk("lhu_mis",   1, 0, 3'b101, 32'h00009003, 32'h0,        32'h0,        5'd14, 1, 0, 0, 0, 32'h0,    32'h0,        4'h0, 0, 1, 0, 0, 32'h0));
    tbl.push_back(mk("sw_tmo",    0, 1, 3'b010, 32'h0000A000, 32'h01234567, 32'h0,        5'd0,  0, 0, 0, 1, 32'hA000, 32'h01234567, 4'hF, 6, 0, 1, 0, 32'h0));
    tbl.push_back(mk("sw_lastgnt",0, 1, 3'b010, 32'h0000A010, 32'h89ABCDEF, 32'h0,        5'd0,  0, 6, 0, 1, 32'hA010, 32'h89ABCDEF, 4'hF, 6, 0, 0, 0, 32'h0));
    tbl.push_back(mk("lw_lastrv", 1, 0, 3'b010, 32'h0000B000, 32'h0,        32'h01020304, 5'd13, 1, 1, 5, 1, 32'hB000, 32'h0,        4'hF, 6, 0, 0, 1, 32'h01020304));
    tbl.push_back(mk("lw_tmo",    1, 0, 3'b010, 32'h0000B004, 32'h0,        32'h05060708, 5'd14, 1, 1, 6, 1, 32'hB004, 32'h0,        4'hF, 6, 0, 1, 0, 32'h0));
    tbl.push_back(mk("lb_pos",    1, 0, 3'b000, 32'h0000C000, 32'h0,        32'hAAAAAA7F, 5'd15, 1, 1, 1, 1, 32'hC000, 32'h0,        4'h1, 2, 0, 0, 1, 32'h0000007F));
    tbl.push_back(mk("nomem_odd", 0, 0, 3'b010, 32'h00000003, 32'h0,        32'h0,        5'd16, 1, 0, 0, 0, 32'h0,    32'h0,        4'h0, 0, 0, 0, 1, 32'h0));

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst.valid", 32'(o_valid), 32'd0);
    chk("rst.req", 32'(dmem.o_dmem_req), 32'd0);
    chk("rst.stall", 32'(o_stall), 32'd0);
    chk("rst.be", 32'(dmem.o_dmem_be), 32'd0);
    chk("rst.ld", o_load_data, 32'd0);
    chk("rst.rd", 32'(o_rd), 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      v.pc  = 32'h1000 + 32'(i) * 4;
      v.src = 2'(i);
      run(v);
    end

    // Reset while a load waits for data; the late rvalid/gnt must be ignored
    @(negedge clk);
    i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0;
    i_funct3 = 3'b000; i_addr = 32'h0000D003; i_rd = 5'd20;
    i_reg_write = 1'b1; i_pc_p4 = 32'h2000;
    dmem.i_dmem_rdata = 32'h80000000;
    @(negedge clk);
    dmem.i_dmem_gnt = 1'b1;
    #1;
    chk("rstw.req", 32'(dmem.o_dmem_req), 32'd1);
    @(negedge clk);
    dmem.i_dmem_gnt = 1'b0;
    #1;
    chk("rstw.stall", 32'(o_stall), 32'd1);
    rst = 1'b1;
    i_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    dmem.i_dmem_rvalid = 1'b1;
    dmem.i_dmem_gnt = 1'b1;
    #1;
    chk("rstw.req0", 32'(dmem.o_dmem_req), 32'd0);
    chk("rstw.valid0", 32'(o_valid), 32'd0);
    chk("rstw.stall0", 32'(o_stall), 32'd0);
    chk("rstw.rd0", 32'(o_rd), 32'd0);
    chk("rstw.alu0", o_alu_result, 32'd0);
    @(negedge clk);
    dmem.i_dmem_rvalid = 1'b0;
    dmem.i_dmem_gnt = 1'b0;
    chk("rstw.valid1", 32'(o_valid), 32'd0);
    chk("rstw.req1", 32'(dmem.o_dmem_req), 32'd0);

    v = tbl[1];
    v.nm  = "lb_after_rst";
    v.pc  = 32'h3000;
    v.src = 2'd3;
    run(v);

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
